// File: rtl/alu_issue_arbiter_if.sv
// Issue-side and CDB-side signals of the shared add/sub ALU arbiter.
// The slave modport is the arbiter; the master modport drives requests and consumes the CDB.
interface alu_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
);
  // Handshakes: a request on port k issues in the cycle req_valid_i[k] & req_ready_o[k];
  // a result transfers in the cycle cdb_valid_o & cdb_ready_i, and may be held
  // indefinitely while cdb_ready_i is low.
  logic                      flush_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_a_i;
  logic [NUM_REQ*DATA_W-1:0] req_b_i;
  logic [NUM_REQ-1:0]        req_op_i;
  logic [NUM_REQ*TAG_W-1:0]  req_tag_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      cdb_valid_o;
  logic                      cdb_ready_i;
  logic [TAG_W-1:0]          cdb_tag_o;
  logic [DATA_W-1:0]         cdb_data_o;
  logic                      cdb_neg_o;
  logic                      cdb_zero_o;
  logic                      busy_o;

  modport slave (
    input  flush_i, req_valid_i, req_a_i, req_b_i, req_op_i, req_tag_i, cdb_ready_i,
    output req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_neg_o, cdb_zero_o, busy_o
  );

  modport master (
    output flush_i, req_valid_i, req_a_i, req_b_i, req_op_i, req_tag_i, cdb_ready_i,
    input  req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_neg_o, cdb_zero_o, busy_o
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one add/sub ALU between issue ports; the result is registered
// and presented on the CDB with its tag, flags and a one-entry EMPTY/FULL output stage.
module alu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_issue_arbiter_if.slave    bus,
  output logic                  dbg_full_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  data_q;
  logic               neg_q;
  logic               zero_q;

  logic [DATA_W-1:0]  a_arr   [NUM_REQ];
  logic [DATA_W-1:0]  b_arr   [NUM_REQ];
  logic [TAG_W-1:0]   tag_arr [NUM_REQ];

  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   ptr_d;
  logic               can_issue;
  logic               grant;
  logic [NUM_REQ-1:0] grant_vec;
  logic [DATA_W-1:0]  alu_res;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k]   = bus.req_a_i[k*DATA_W +: DATA_W];
      b_arr[k]   = bus.req_b_i[k*DATA_W +: DATA_W];
      tag_arr[k] = bus.req_tag_i[k*TAG_W +: TAG_W];
    end
  end

  // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign can_issue = (state_q == EMPTY) || bus.cdb_ready_i;
  assign grant     = found && can_issue && !bus.flush_i && !rst_i;
  assign grant_vec = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign ptr_d     = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  assign alu_res   = bus.req_op_i[win_idx] ? (a_arr[win_idx] - b_arr[win_idx])
                                           : (a_arr[win_idx] + b_arr[win_idx]);

  // Flush wins over a pending drain; on flush the stale payload is left in place but invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= EMPTY;
    end else if (grant) begin
      state_q <= FULL;
      ptr_q   <= ptr_d;
      tag_q   <= tag_arr[win_idx];
      data_q  <= alu_res;
      neg_q   <= alu_res[DATA_W-1];
      zero_q  <= (alu_res == '0);
    end else if (state_q == FULL && bus.cdb_ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign bus.req_ready_o = grant_vec;
  assign bus.cdb_valid_o = (state_q == FULL);
  assign bus.busy_o      = (state_q == FULL);
  assign bus.cdb_tag_o   = tag_q;
  assign bus.cdb_data_o  = data_q;
  assign bus.cdb_neg_o   = neg_q;
  assign bus.cdb_zero_o  = zero_q;
  assign dbg_full_o      = (state_q == FULL);
endmodule
